// File: rtl/bird_column_if.sv
// Player/display bundle for the bird_column light-column game.
interface bird_column_if #(
    parameter int unsigned ROWS = 8
);
    localparam int unsigned POS_W = $clog2(ROWS);

    logic             press;
    logic             enable;
    logic             restart;
    logic [ROWS-1:0]  lights;
    logic [POS_W-1:0] pos;
    logic             at_top;
    logic             at_bottom;
    logic             crashed;

    modport master (
        output press, enable, restart,
        input  lights, pos, at_top, at_bottom, crashed
    );

    modport slave (
        input  press, enable, restart,
        output lights, pos, at_top, at_bottom, crashed
    );
endinterface

// File: rtl/bird_column.sv
// One-column flappy-bird: flaps lift the bird, a divided gravity tick drops it.
// Optional macro BIRD_CRASH_EN: hitting the floor latches a crash until restart.
module bird_column #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned GRAV_DIV  = 4,
    parameter int unsigned FLAP_ROWS = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    bird_column_if.slave  bus
);
    localparam int unsigned POS_W = $clog2(ROWS);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = POS_W + 5;

    localparam logic [POS_W-1:0] POS_START = POS_W'(ROWS / 2);
    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GRAV_DIV - 1);

`ifdef BIRD_CRASH_EN
    localparam bit CRASH_EN = 1'b1;
`else
    localparam bit CRASH_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_FLY     = 1'b0,
        ST_CRASHED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    logic             flap_c;
    logic             tick_c;
    logic [SUM_W-1:0] rise_c;
    logic [ROWS-1:0]  lights_c;

    // Press edge register resets high so a button held through reset is not a flap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FLY;
            pos_q   <= POS_START;
            cnt_q   <= '0;
            press_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        press_d = bus.press;

        flap_c = bus.enable & bus.press & ~press_q;
        tick_c = bus.enable & (cnt_q == CNT_LAST);
        // A tick in the flap cycle cancels one row of the lift.
        rise_c = SUM_W'(pos_q) + (tick_c ? SUM_W'(FLAP_ROWS - 1) : SUM_W'(FLAP_ROWS));

        if (bus.restart) begin
            state_d = ST_FLY;
            pos_d   = POS_START;
            cnt_d   = '0;
        end else if (bus.enable) begin
            case (state_q)
                ST_FLY: begin
                    if (flap_c) begin
                        cnt_d = '0;
                        pos_d = (rise_c > SUM_W'(ROWS - 1)) ? POS_TOP : POS_W'(rise_c);
                    end else if (tick_c) begin
                        cnt_d = '0;
                        if (pos_q != '0) begin
                            pos_d = pos_q - POS_W'(1);
                        end else if (CRASH_EN) begin
                            state_d = ST_CRASHED;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CRASHED: begin
                    state_d = ST_CRASHED;
                end
                default: begin
                    state_d = ST_FLY;
                end
            endcase
        end
    end

    always_comb begin
        lights_c        = '0;
        lights_c[pos_q] = 1'b1;
    end

    assign bus.lights    = lights_c;
    assign bus.pos       = pos_q;
    assign bus.at_top    = (pos_q == POS_TOP);
    assign bus.at_bottom = (pos_q == '0);
    assign bus.crashed   = (state_q == ST_CRASHED);
endmodule

// File: tb/tb_bird_column.sv
// Bench for bird_column: two instances (FLAP_ROWS 1 and 3) against a behavioural model.
module tb_bird_column;
    localparam int R = 8;
    localparam int G = 4;

`ifdef BIRD_CRASH_EN
    localparam bit CRASH = 1'b1;
`else
    localparam bit CRASH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic press = 1'b0;
    logic enable = 1'b0;
    logic restart = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bird_column_if #(.ROWS(R)) bif0 ();
    bird_column_if #(.ROWS(R)) bif3 ();

    assign bif0.press = press;   assign bif3.press = press;
    assign bif0.enable = enable; assign bif3.enable = enable;
    assign bif0.restart = restart; assign bif3.restart = restart;

    bird_column #(.ROWS(R), .GRAV_DIV(G), .FLAP_ROWS(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bif0));
    bird_column #(.ROWS(R), .GRAV_DIV(G), .FLAP_ROWS(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bif3));

    logic [2:0] o_pos[2];
    logic [7:0] o_lights[2];
    logic       o_top[2], o_bot[2], o_crash[2];
    assign o_pos[0] = bif0.pos;          assign o_pos[1] = bif3.pos;
    assign o_lights[0] = bif0.lights;    assign o_lights[1] = bif3.lights;
    assign o_top[0] = bif0.at_top;       assign o_top[1] = bif3.at_top;
    assign o_bot[0] = bif0.at_bottom;    assign o_bot[1] = bif3.at_bottom;
    assign o_crash[0] = bif0.crashed;    assign o_crash[1] = bif3.crashed;

    // Reference: bird height, enabled cycles since the gravity phase last restarted.
    int m_pos[2];
    int m_since[2];
    bit m_crash[2];
    bit m_prev;

    function automatic int lift(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pos[k] <= R / 2; m_since[k] <= 0; m_crash[k] <= 1'b0;
            end
            m_prev <= 1'b1;
        end else begin
            m_prev <= press;
            for (int k = 0; k < 2; k++) begin
                if (restart) begin
                    m_pos[k] <= R / 2; m_since[k] <= 0; m_crash[k] <= 1'b0;
                end else if (enable && !m_crash[k]) begin
                    if (press && !m_prev) begin
                        m_pos[k] <= imin(m_pos[k] + lift(k) - ((m_since[k] == G - 1) ? 1 : 0), R - 1);
                        m_since[k] <= 0;
                    end else if (m_since[k] == G - 1) begin
                        m_since[k] <= 0;
                        if (m_pos[k] > 0) m_pos[k] <= m_pos[k] - 1;
                        else m_crash[k] <= CRASH;
                    end else begin
                        m_since[k] <= m_since[k] + 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_restart();
        restart = 1'b1; step(); restart = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_pos[k] !== 3'd4 || o_lights[k] !== 8'h10 || o_crash[k] !== 1'b0
                || o_top[k] !== 1'b0 || o_bot[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d pos=%0d lights=%h crash=%b top=%b bot=%b expected pos=4 lights=10 crash=0 top=0 bot=0",
                         k, o_pos[k], o_lights[k], o_crash[k], o_top[k], o_bot[k]);
            end
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_gravity();
        enable = 1'b1; press = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            checks++;
            if (o_pos[0] !== 3'(4 - c / 4) || o_pos[1] !== 3'(4 - c / 4)) begin
                failures++;
                $display("FAIL gravity cycle=%0d pos=%0d/%0d expected %0d", c, o_pos[0], o_pos[1], 4 - c / 4);
            end
        end
        checks++;
        if (o_lights[0] !== 8'h01 || o_bot[0] !== 1'b1 || o_top[0] !== 1'b0) begin
            failures++;
            $display("FAIL gravity_floor lights=%h bot=%b top=%b expected lights=01 bot=1 top=0",
                     o_lights[0], o_bot[0], o_top[0]);
        end
    endtask

    task automatic test_flap_hold();
        do_restart();
        enable = 1'b1;
        step(); step();
        press = 1'b1;
        step();
        checks++;
        if (o_pos[1] !== 3'd7 || o_top[1] !== 1'b1 || o_pos[0] !== 3'd5) begin
            failures++;
            $display("FAIL flap_sat pos3=%0d top3=%b pos1=%0d expected pos3=7 top3=1 pos1=5", o_pos[1], o_top[1], o_pos[0]);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_pos[k] !== 3'(m_pos[k]) || o_lights[k] !== 8'(1 << m_pos[k])) begin
                    failures++;
                    $display("FAIL flap_hold dut%0d c=%0d pos=%0d lights=%h expected pos=%0d", k, c, o_pos[k], o_lights[k], m_pos[k]);
                end
            end
        end
        // Held press: one flap then ticks at cycles 4 and 8 after it.
        checks++;
        if (o_pos[1] !== 3'd5 || o_pos[0] !== 3'd3) begin
            failures++;
            $display("FAIL flap_once pos3=%0d pos1=%0d expected pos3=5 pos1=3", o_pos[1], o_pos[0]);
        end
        press = 1'b0;
    endtask

    task automatic test_coincident();
        do_restart();
        enable = 1'b1; press = 1'b0;
        repeat (7) step();
        press = 1'b1;
        step();
        press = 1'b0;
        checks++;
        if (o_pos[0] !== 3'd3 || o_pos[1] !== 3'd5) begin
            failures++;
            $display("FAIL coincident pos1=%0d pos3=%0d expected pos1=3 pos3=5", o_pos[0], o_pos[1]);
        end
        repeat (3) step();
        checks++;
        if (o_pos[0] !== 3'd3) begin
            failures++;
            $display("FAIL coincident_hold pos=%0d expected 3", o_pos[0]);
        end
        step();
        checks++;
        if (o_pos[0] !== 3'd2) begin
            failures++;
            $display("FAIL coincident_next_tick pos=%0d expected 2", o_pos[0]);
        end
    endtask

    task automatic test_freeze();
        do_restart();
        enable = 1'b1;
        press = 1'b1; step(); press = 1'b0;
        step(); step();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            press = (i % 2 == 1);
            step();
            checks++;
            if (o_pos[0] !== 3'd5 || o_pos[1] !== 3'd7) begin
                failures++;
                $display("FAIL freeze i=%0d pos1=%0d pos3=%0d expected pos1=5 pos3=7", i, o_pos[0], o_pos[1]);
            end
        end
        press = 1'b0; step();
        enable = 1'b1;
        step();
        checks++;
        if (o_pos[0] !== 3'd5) begin
            failures++;
            $display("FAIL freeze_resume pos=%0d expected 5", o_pos[0]);
        end
        step();
        checks++;
        if (o_pos[0] !== 3'd4 || o_pos[1] !== 3'd6) begin
            failures++;
            $display("FAIL freeze_tick pos1=%0d pos3=%0d expected pos1=4 pos3=6", o_pos[0], o_pos[1]);
        end
    endtask

    task automatic test_crash();
        do_restart();
        enable = 1'b1; press = 1'b0;
        repeat (20) step();
        checks++;
        if (o_pos[0] !== 3'd0 || o_crash[0] !== CRASH) begin
            failures++;
            $display("FAIL crash pos=%0d crashed=%b expected pos=0 crashed=%b", o_pos[0], o_crash[0], CRASH);
        end
        press = 1'b1; step(); press = 1'b0; step();
        checks++;
        if (o_pos[0] !== (CRASH ? 3'd0 : 3'd1) || o_crash[0] !== CRASH) begin
            failures++;
            $display("FAIL crash_press pos=%0d crashed=%b expected pos=%0d crashed=%b",
                     o_pos[0], o_crash[0], CRASH ? 0 : 1, CRASH);
        end
        do_restart();
        checks++;
        if (o_pos[0] !== 3'd4 || o_crash[0] !== 1'b0 || o_crash[1] !== 1'b0) begin
            failures++;
            $display("FAIL crash_restart pos=%0d crashed=%b/%b expected pos=4 crashed=0", o_pos[0], o_crash[0], o_crash[1]);
        end
    endtask

    task automatic test_async_reset();
        do_restart();
        enable = 1'b1; press = 1'b0;
        repeat (14) step();
        checks++;
        if (o_pos[0] !== 3'd1) begin
            failures++;
            $display("FAIL async_setup pos=%0d expected 1", o_pos[0]);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (o_pos[0] !== 3'd4 || o_lights[0] !== 8'h10) begin
            failures++;
            $display("FAIL async_reset pos=%0d lights=%h expected pos=4 lights=10", o_pos[0], o_lights[0]);
        end
        press = 1'b1;
        #2 reset_n = 1'b1;
        repeat (3) step();
        checks++;
        if (o_pos[0] !== 3'd4 || o_pos[1] !== 3'd4) begin
            failures++;
            $display("FAIL reset_held_press pos1=%0d pos3=%0d expected 4", o_pos[0], o_pos[1]);
        end
        step();
        checks++;
        if (o_pos[0] !== 3'd3) begin
            failures++;
            $display("FAIL reset_first_tick pos=%0d expected 3", o_pos[0]);
        end
        press = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enable  = ($urandom_range(0, 99) < 85);
            restart = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 30) press = ~press;
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_pos[k] !== 3'(m_pos[k]) || o_lights[k] !== 8'(1 << m_pos[k])
                    || o_top[k] !== (m_pos[k] == R - 1) || o_bot[k] !== (m_pos[k] == 0)
                    || o_crash[k] !== m_crash[k]) begin
                    failures++;
                    $display("FAIL random dut%0d c=%0d pos=%0d lights=%h top=%b bot=%b crash=%b expected pos=%0d crash=%b",
                             k, c, o_pos[k], o_lights[k], o_top[k], o_bot[k], o_crash[k], m_pos[k], m_crash[k]);
                end
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_flap_hold();
        test_coincident();
        test_freeze();
        test_crash();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
